acondicionador_conmutadores: RTL and testbench

- Input-conditioning stage placed directly upstream of the Hamming encode/decode datapath.
- Takes the 12 raw, asynchronous slide-switch inputs (4 data bits, 8 received-word bits) and synchronises each one into clk. Debounces each bit independently.
- Drives the clean conmutador_4 / conmutador_8 buses consumed by the encoder, receptor and corrector stages.
- Emits a one-cycle change strobe and a settled flag so downstream logic and display can react only to stable words.

---
 rtl/acondicionador_conmutadores_if.sv | 19 +
 rtl/acondicionador_conmutadores.sv | 118 +++++++++++
 tb/tb_acondicionador_conmutadores.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/acondicionador_conmutadores_if.sv
// Switch-conditioning bus: raw asynchronous switch words in, debounced words plus status out.
interface acondicionador_conmutadores_if;
  logic [3:0] sw_raw_4;
  logic [7:0] sw_raw_8;
  logic [3:0] conmutador_4;
  logic [7:0] conmutador_8;
  logic       cambio;
  logic       estable;

  modport master (
    output sw_raw_4, sw_raw_8,
    input  conmutador_4, conmutador_8, cambio, estable
  );

  modport slave (
    input  sw_raw_4, sw_raw_8,
    output conmutador_4, conmutador_8, cambio, estable
  );
endinterface

// File: rtl/acondicionador_conmutadores.sv
// Synchronises and debounces 12 slide-switch bits feeding the Hamming datapath.
// Optional macro CONMUT_ATOMIC_EN: commit all settled bits together as one word.
module acondicionador_conmutadores #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  acondicionador_conmutadores_if.slave bus
);
  localparam int NB = 12;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef CONMUT_ATOMIC_EN
  localparam logic [CW-1:0] CNT_READY = CW'(DEBOUNCE_CYCLES);
`else
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
`endif

  typedef enum logic {IDLE, PEND} bitState_t;

  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] y;
  logic [NB-1:0] s_q, s_d;
  logic [NB-1:0] commit;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic          cambio_q;
  bitState_t     state [NB];
`ifdef CONMUT_ATOMIC_EN
  logic [NB-1:0] ready;
  logic [NB-1:0] pending;
  logic          commitAll;
`endif

  assign y = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state[i] = (y[i] == s_q[i]) ? IDLE : PEND;
    end
  end

`ifdef CONMUT_ATOMIC_EN
  // Bits saturate at the threshold and wait until every pending bit is ready.
  always_comb begin
    s_d       = s_q;
    commit    = '0;
    ready     = '0;
    pending   = '0;
    commitAll = 1'b0;
    for (int i = 0; i < NB; i++) begin
      pending[i] = (state[i] == PEND);
      ready[i]   = (state[i] == PEND) && (cnt_q[i] == CNT_READY);
    end
    commitAll = (|ready) && ((pending & ~ready) == '0);
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (state[i] == PEND) begin
        if (cnt_q[i] == CNT_READY) begin
          if (commitAll) begin
            commit[i] = 1'b1;
            s_d[i]    = y[i];
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end
`else
  // Each bit commits on its own once it has differed for the full window.
  always_comb begin
    s_d    = s_q;
    commit = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (state[i] == PEND) begin
        if (cnt_q[i] == CNT_LAST) begin
          commit[i] = 1'b1;
          s_d[i]    = y[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
      s_q      <= '0;
      cambio_q <= 1'b0;
    end else begin
      sync_q[0] <= {bus.sw_raw_8, bus.sw_raw_4};
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      s_q      <= s_d;
      cambio_q <= |commit;
    end
  end

  assign bus.conmutador_4 = s_q[3:0];
  assign bus.conmutador_8 = s_q[11:4];
  assign bus.cambio       = cambio_q;
  assign bus.estable      = &(~(y ^ s_q));
endmodule

// File: tb/tb_acondicionador_conmutadores.sv
// Directed bench for the switch conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
module tb_acondicionador_conmutadores;
  localparam int DEB = 8;
  localparam int SYN = 2;
`ifdef CONMUT_ATOMIC_EN
  localparam int COMMIT_EDGE = SYN + DEB;
`else
  localparam int COMMIT_EDGE = SYN + DEB - 1;
`endif

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;
  int   cambioPulses;
  int   pulseBase;
  logic bounceVal;

  acondicionador_conmutadores_if bus();

  acondicionador_conmutadores #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES(SYN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (bus.cambio === 1'b1) cambioPulses++;
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] raw4, input logic [7:0] raw8);
    bus.sw_raw_4 = raw4;
    bus.sw_raw_8 = raw8;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic logic [11:0] word();
    return {bus.conmutador_8, bus.conmutador_4};
  endfunction

  initial begin
    testCount    = 0;
    failCount    = 0;
    cambioPulses = 0;
    bounceVal    = 1'b0;

    rst = 1'b1;
    applyStimulus(4'h0, 8'hFF);
    waitEdges(3);
    checkOutput("resetWord", word(), 12'h000);
    checkOutput("resetCambio", 12'(bus.cambio), 12'h0);
    checkOutput("resetEstable", 12'(bus.estable), 12'h1);

    rst = 1'b0;
    pulseBase = cambioPulses;
    waitEdges(COMMIT_EDGE);
    checkOutput("releaseHold", word(), 12'h000);
    waitEdges(1);
    checkOutput("releaseCommit", word(), 12'hFF0);
    checkOutput("releaseCambio", 12'(bus.cambio), 12'h1);
    waitEdges(1);
    checkOutput("releaseCambioDrop", 12'(bus.cambio), 12'h0);
    checkOutput("releasePulses", 12'(cambioPulses - pulseBase), 12'h1);

    pulseBase = cambioPulses;
    applyStimulus(4'h5, 8'hFF);
    waitEdges(5);
    applyStimulus(4'h0, 8'hFF);
    waitEdges(15);
    checkOutput("glitchWord", word(), 12'hFF0);
    checkOutput("glitchPulses", 12'(cambioPulses - pulseBase), 12'h0);
    checkOutput("glitchEstable", 12'(bus.estable), 12'h1);

    applyStimulus(4'h0, 8'h00);
    waitEdges(COMMIT_EDGE + 3);
    checkOutput("clearWord", word(), 12'h000);
    pulseBase = cambioPulses;
    applyStimulus(4'hA, 8'h3C);
    waitEdges(1);
    checkOutput("simEstableEdge0", 12'(bus.estable), 12'h1);
    waitEdges(1);
    checkOutput("simEstableEdge1", 12'(bus.estable), 12'h0);
    waitEdges(COMMIT_EDGE - 2);
    checkOutput("simHold", word(), 12'h000);
    waitEdges(1);
    checkOutput("simCommit", word(), 12'h3CA);
    checkOutput("simCambio", 12'(bus.cambio), 12'h1);
    checkOutput("simEstable", 12'(bus.estable), 12'h1);
    waitEdges(1);
    checkOutput("simCambioDrop", 12'(bus.cambio), 12'h0);
    checkOutput("simPulses", 12'(cambioPulses - pulseBase), 12'h1);

    applyStimulus(4'h0, 8'h00);
    waitEdges(COMMIT_EDGE + 3);
    checkOutput("midClearWord", word(), 12'h000);
    applyStimulus(4'h0, 8'h81);
    waitEdges(7);
    rst = 1'b1;
    waitEdges(2);
    checkOutput("midResetWord", word(), 12'h000);
    checkOutput("midResetEstable", 12'(bus.estable), 12'h1);
    rst = 1'b0;
    waitEdges(COMMIT_EDGE);
    checkOutput("midHold", word(), 12'h000);
    waitEdges(1);
    checkOutput("midCommit", word(), 12'h810);
    checkOutput("midCambio", 12'(bus.cambio), 12'h1);

    applyStimulus(4'h0, 8'h00);
    waitEdges(COMMIT_EDGE + 3);
    checkOutput("stagClearWord", word(), 12'h000);
    pulseBase = cambioPulses;
    applyStimulus(4'h0, 8'h01);
    waitEdges(3);
    applyStimulus(4'h0, 8'h81);
    waitEdges(COMMIT_EDGE - 3);
    checkOutput("stagHold", word(), 12'h000);
`ifdef CONMUT_ATOMIC_EN
    waitEdges(3);
    checkOutput("stagAtomicHold", word(), 12'h000);
    checkOutput("stagAtomicNoPulse", 12'(cambioPulses - pulseBase), 12'h0);
    waitEdges(1);
    checkOutput("stagAtomicCommit", word(), 12'h810);
    checkOutput("stagAtomicCambio", 12'(bus.cambio), 12'h1);
    waitEdges(1);
    checkOutput("stagPulses", 12'(cambioPulses - pulseBase), 12'h1);
`else
    waitEdges(1);
    checkOutput("stagFirstCommit", word(), 12'h010);
    checkOutput("stagFirstCambio", 12'(bus.cambio), 12'h1);
    waitEdges(2);
    checkOutput("stagGapWord", word(), 12'h010);
    checkOutput("stagGapCambio", 12'(bus.cambio), 12'h0);
    waitEdges(1);
    checkOutput("stagSecondCommit", word(), 12'h810);
    checkOutput("stagSecondCambio", 12'(bus.cambio), 12'h1);
    waitEdges(1);
    checkOutput("stagPulses", 12'(cambioPulses - pulseBase), 12'h2);
`endif

    pulseBase = cambioPulses;
    for (int t = 0; t < 10; t++) begin
      bounceVal = ~bounceVal;
      applyStimulus({3'b000, bounceVal}, 8'h81);
      waitEdges(3);
    end
    checkOutput("bounceTrainWord", word(), 12'h810);
    checkOutput("bounceTrainPulses", 12'(cambioPulses - pulseBase), 12'h0);
    applyStimulus(4'h1, 8'h81);
    waitEdges(COMMIT_EDGE);
    checkOutput("bounceHold", word(), 12'h810);
    waitEdges(1);
    checkOutput("bounceCommit", word(), 12'h811);
    checkOutput("bounceCambio", 12'(bus.cambio), 12'h1);
    waitEdges(1);
    checkOutput("bouncePulses", 12'(cambioPulses - pulseBase), 12'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
